// File: rtl/mmio_keyboard.sv
// rtl/mmio_keyboard.sv - Hack keyboard MMIO register (0x6000) fed by debounced push-buttons
// Optional sticky capture mode: define KEYBOARD_LATCH_EN.
module mmio_keyboard #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int KEY_BASE        = 130,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic [15:0]            address,
  input  logic                   load,
  output logic [15:0]            out,
  output logic                   kbd_hit
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]     KBD_ADDR = 16'h6000;

  logic [NUM_BUTTONS-1:0] pressed_raw;
  logic [NUM_BUTTONS-1:0] s1;
  logic [NUM_BUTTONS-1:0] s2;
  logic [NUM_BUTTONS-1:0] deb;
  logic [CW-1:0]          cnt [NUM_BUTTONS];
  logic [15:0]            code;
  logic [15:0]            key_reg;

  // Normalise polarity so that 1 always means pressed from s1 onward.
  assign pressed_raw = (ACTIVE_LOW != 0) ? ~buttons : buttons;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pressed_raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Scan from the top down so the lowest pressed index is written last and wins.
  always_comb begin
    code = 16'h0000;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (deb[i]) code = 16'(KEY_BASE + i);
    end
  end

  assign kbd_hit = (address == KBD_ADDR);

`ifdef KEYBOARD_LATCH_EN
  // A CPU write to the register clears it; clear beats a same-edge capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg <= 16'h0000;
    end else if (load && kbd_hit) begin
      key_reg <= 16'h0000;
    end else if (key_reg == 16'h0000 && code != 16'h0000) begin
      key_reg <= code;
    end
  end
`else
  logic unused_load;
  assign unused_load = load;

  always_ff @(posedge clk) begin
    if (rst) key_reg <= 16'h0000;
    else     key_reg <= code;
  end
`endif

  assign out = kbd_hit ? key_reg : 16'h0000;

endmodule

// File: tb/tb_mmio_keyboard.sv
// tb/tb_mmio_keyboard.sv - directed self-checking bench for mmio_keyboard (DEBOUNCE_CYCLES=4)
module tb_mmio_keyboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  buttons;
  logic [15:0] address;
  logic        load;
  logic [15:0] out;
  logic        kbd_hit;

  int n_cmp = 0;
  int n_err = 0;

  mmio_keyboard #(
    .NUM_BUTTONS(4),
    .DEBOUNCE_CYCLES(4),
    .KEY_BASE(130),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .buttons(buttons),
    .address(address),
    .load(load),
    .out(out),
    .kbd_hit(kbd_hit)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; buttons = 4'hF; address = 16'h6000; load = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    n_cmp++; if (out !== 16'h0000) begin n_err++; $display("FAIL reset_out got=%0d exp=0", out); end
    n_cmp++; if (kbd_hit !== 1'b1) begin n_err++; $display("FAIL reset_hit got=%b exp=1", kbd_hit); end
    address = 16'h4000; #1;
    n_cmp++; if (kbd_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit_other got=%b exp=0", kbd_hit); end
    n_cmp++; if (out !== 16'h0000) begin n_err++; $display("FAIL reset_out_other got=%0d exp=0", out); end
    address = 16'h6000; #1;
  endtask

  task automatic test_press_release();
    buttons = 4'b1011;
    tick(6);
    n_cmp++; if (out !== 16'd0) begin n_err++; $display("FAIL press_edge6 got=%0d exp=0", out); end
    tick(1);
    n_cmp++; if (out !== 16'd132) begin n_err++; $display("FAIL press_edge7 got=%0d exp=132", out); end
    address = 16'h4000; #1;
    n_cmp++; if (out !== 16'd0) begin n_err++; $display("FAIL press_other_addr got=%0d exp=0", out); end
    address = 16'h6000; load = 1'b1;
    tick(1);
    load = 1'b0;
    n_cmp++; if (out !== 16'd132) begin n_err++; $display("FAIL live_write_ignored got=%0d exp=132", out); end
    buttons = 4'hF;
    tick(6);
    n_cmp++; if (out !== 16'd132) begin n_err++; $display("FAIL release_edge6 got=%0d exp=132", out); end
    tick(1);
    n_cmp++; if (out !== 16'd0) begin n_err++; $display("FAIL release_edge7 got=%0d exp=0", out); end
  endtask

  task automatic test_glitch();
    int nonzero;
    int windows;
    int width;
    logic [15:0] prev;
    nonzero = 0;
    buttons = 4'hE;
    tick(3);
    buttons = 4'hF;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (out !== 16'd0) nonzero++;
    end
    n_cmp++; if (nonzero !== 0) begin n_err++; $display("FAIL glitch3_nonzero got=%0d exp=0", nonzero); end
    windows = 0; width = 0; prev = 16'd0;
    buttons = 4'hE;
    tick(4);
    buttons = 4'hF;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (out === 16'd130) width++;
      if (out === 16'd130 && prev !== 16'd130) windows++;
      prev = out;
    end
    n_cmp++; if (windows !== 1) begin n_err++; $display("FAIL glitch4_windows got=%0d exp=1", windows); end
    n_cmp++; if (width !== 4) begin n_err++; $display("FAIL glitch4_width got=%0d exp=4", width); end
  endtask

  task automatic test_priority();
    buttons = 4'b0101;
    tick(7);
    n_cmp++; if (out !== 16'd131) begin n_err++; $display("FAIL prio_both got=%0d exp=131", out); end
    buttons = 4'b0111;
    tick(6);
    n_cmp++; if (out !== 16'd131) begin n_err++; $display("FAIL prio_rel_edge6 got=%0d exp=131", out); end
    tick(1);
    n_cmp++; if (out !== 16'd133) begin n_err++; $display("FAIL prio_next got=%0d exp=133", out); end
    buttons = 4'hF;
    tick(10);
    n_cmp++; if (out !== 16'd0) begin n_err++; $display("FAIL prio_all_released got=%0d exp=0", out); end
  endtask

  task automatic test_reset_mid();
    buttons = 4'hE;
    tick(3);
    rst = 1'b1;
    tick(1);
    n_cmp++; if (out !== 16'd0) begin n_err++; $display("FAIL rstmid_edge4 got=%0d exp=0", out); end
    tick(1);
    n_cmp++; if (out !== 16'd0) begin n_err++; $display("FAIL rstmid_edge5 got=%0d exp=0", out); end
    rst = 1'b0;
    tick(6);
    n_cmp++; if (out !== 16'd0) begin n_err++; $display("FAIL rstmid_post6 got=%0d exp=0", out); end
    tick(1);
    n_cmp++; if (out !== 16'd130) begin n_err++; $display("FAIL rstmid_post7 got=%0d exp=130", out); end
    buttons = 4'hF;
    tick(10);
  endtask

`ifdef KEYBOARD_LATCH_EN
  task automatic test_latch();
    buttons = 4'b1101;
    tick(7);
    n_cmp++; if (out !== 16'd131) begin n_err++; $display("FAIL latch_capture got=%0d exp=131", out); end
    buttons = 4'hF;
    tick(12);
    n_cmp++; if (out !== 16'd131) begin n_err++; $display("FAIL latch_hold got=%0d exp=131", out); end
    load = 1'b1;
    tick(1);
    load = 1'b0;
    n_cmp++; if (out !== 16'd0) begin n_err++; $display("FAIL latch_clear got=%0d exp=0", out); end
    tick(1);
    n_cmp++; if (out !== 16'd0) begin n_err++; $display("FAIL latch_clear_stays got=%0d exp=0", out); end
    buttons = 4'b1101;
    tick(8);
    n_cmp++; if (out !== 16'd131) begin n_err++; $display("FAIL latch_recapture got=%0d exp=131", out); end
    load = 1'b1;
    tick(1);
    load = 1'b0;
    n_cmp++; if (out !== 16'd0) begin n_err++; $display("FAIL latch_clear_held got=%0d exp=0", out); end
    tick(1);
    n_cmp++; if (out !== 16'd131) begin n_err++; $display("FAIL latch_held_again got=%0d exp=131", out); end
    buttons = 4'hF;
    tick(10);
  endtask
`endif

  initial begin
    test_reset();
`ifdef KEYBOARD_LATCH_EN
    test_latch();
`else
    test_press_release();
    test_glitch();
    test_priority();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
